// File: rtl/capture_pkg.sv
// Shared definitions for the FIR capture buffer: FSM encodings, default sizes
// and the depth helper.
package capture_pkg;

  // o_state exposes these encodings directly, so the values are fixed.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2,
    StRead    = 2'd3
  } state_e;

  localparam int unsigned NbDataDefault = 13;
  localparam int unsigned NbAddrDefault = 10;

  // Number of samples addressable with nb_addr address bits.
  function automatic int unsigned depth(input int unsigned nb_addr);
    return 32'd1 << nb_addr;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port. No reset on
// the array or read register so it maps onto block RAM.
module ram_sdp
  import capture_pkg::*;
#(
  parameter int unsigned NB_DATA = NbDataDefault,
  parameter int unsigned NB_ADDR = NbAddrDefault
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic               rd_en,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  localparam int unsigned Depth = depth(NB_ADDR);

  logic [NB_DATA-1:0] mem [Depth];

  // Synchronous write and synchronous read; rd_data holds when rd_en is low.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_capture_ram.sv
// Capture buffer behind the PRBS->FIR chain: fills a RAM with FIR samples on
// each valid strobe, then streams the buffer back out in address order.
module fir_capture_ram
  import capture_pkg::*;
#(
  parameter int unsigned NB_DATA = NbDataDefault,
  parameter int unsigned NB_ADDR = NbAddrDefault
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_start,
  input  logic               i_read,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_full,
  output logic               o_busy,
  output logic [1:0]         o_state
);

  localparam logic [NB_ADDR-1:0] AddrLast = NB_ADDR'(depth(NB_ADDR) - 1);

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  // Set once the last address has been issued; READ spends one more cycle
  // so the final sample lands in the first IDLE cycle.
  logic               rd_last_q, rd_last_d;
  // An address was issued last enabled cycle; its data is in ram_rdata.
  logic               rd_pend_q;
  logic               valid_q;
  logic [NB_DATA-1:0] data_q;
  logic               full_q;
  logic               busy_q;

  logic               ram_we;
  logic               ram_re;
  logic [NB_DATA-1:0] ram_rdata;

  ram_sdp #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (i_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  // Next-state, pointer and RAM strobe decode; everything holds while disabled.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_last_d = rd_last_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (i_enable) begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d  = StCapture;
            wr_ptr_d = '0;
          end
        end
        StCapture: begin
          if (i_valid) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == AddrLast) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          // Start wins over read: re-arm and drop the old contents.
          if (i_start) begin
            state_d  = StCapture;
            wr_ptr_d = '0;
          end else if (i_read) begin
            state_d   = StRead;
            rd_ptr_d  = '0;
            rd_last_d = 1'b0;
          end
        end
        StRead: begin
          if (rd_last_q) begin
            state_d   = StIdle;
            rd_last_d = 1'b0;
          end else begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == AddrLast) begin
              rd_last_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // FSM state, pointers and registered status outputs.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_last_q <= 1'b0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_last_q <= rd_last_d;
      full_q    <= (state_d == StDone);
      busy_q    <= (state_d == StCapture) || (state_d == StRead);
    end
  end

  // Readout pipeline: the issue stage and RAM output freeze while disabled,
  // so the sample in flight is delivered first when enable returns.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else if (i_enable) begin
      rd_pend_q <= ram_re;
      valid_q   <= rd_pend_q;
      if (rd_pend_q) begin
        data_q <= ram_rdata;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o_data       = data_q;
  // Gated so a disabled cycle never reports valid, even before the next edge.
  assign o_data_valid = valid_q & i_enable;
  assign o_full       = full_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_fir_capture_ram.sv
// Bench for fir_capture_ram with an 8-deep buffer and valid every 8 clocks.
// Expected read samples go into a queue; a negedge monitor checks them.
module tb_fir_capture_ram;

  localparam int unsigned NbData = 13;
  localparam int unsigned NbAddr = 3;

  logic              clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_enable = 1'b1;
  logic              i_valid = 1'b0;
  logic [NbData-1:0] i_data = '0;
  logic              i_start = 1'b0;
  logic              i_read = 1'b0;
  logic [NbData-1:0] o_data;
  logic              o_data_valid;
  logic              o_full;
  logic              o_busy;
  logic [1:0]        o_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [NbData-1:0] exp_q [$];

  fir_capture_ram #(
    .NB_DATA (NbData),
    .NB_ADDR (NbAddr)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_start      (i_start),
    .i_read       (i_read),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_full       (o_full),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every presented sample must match the queue head.
  always @(negedge clock) begin
    if (o_data_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got data %h valid 1, required no valid", o_data);
      end else begin
        logic [NbData-1:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          n_fail++;
          $display("FAIL read_data: got %h, required %h", o_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pulse_read();
    i_read = 1'b1;
    tick();
    i_read = 1'b0;
  endtask

  // One valid strobe followed by the 7 idle clocks of the FIR cadence.
  task automatic write_sample(input logic [NbData-1:0] d);
    i_data  = d;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  logic [NbData-1:0] neg_vec [8] = '{13'h1FFF, 13'h1000, 13'h0FFF, 13'h0AAA,
                                     13'h1555, 13'h0004, 13'h1800, 13'h07FF};

  initial begin
    // Reset state.
    repeat (2) tick();
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_full", 32'(o_full), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_valid", 32'(o_data_valid), 32'd0);
    i_reset = 1'b1;
    tick();

    // Full capture 1..8 and readout.
    pulse_start();
    check("start_state", 32'(o_state), 32'd1);
    check("start_busy", 32'(o_busy), 32'd1);
    for (int i = 1; i <= 7; i++) write_sample(NbData'(i));
    check("full_before_8th", 32'(o_full), 32'd0);
    i_data  = 13'h0008;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("full_on_8th", 32'(o_full), 32'd1);
    check("done_state", 32'(o_state), 32'd2);
    check("done_busy", 32'(o_busy), 32'd0);
    repeat (7) tick();
    for (int i = 1; i <= 8; i++) exp_q.push_back(NbData'(i));
    pulse_read();
    check("read_state", 32'(o_state), 32'd3);
    check("read_full_drop", 32'(o_full), 32'd0);
    tick();
    check("read_lat_edge1", 32'(o_data_valid), 32'd0);
    tick();
    check("read_lat_edge2", 32'(o_data_valid), 32'd1);
    drain("readout1_complete", 20);
    check("readout1_idle", 32'(o_state), 32'd0);
    repeat (3) tick();

    // Ignored read in IDLE, negative values, ignored start mid-capture.
    pulse_read();
    check("read_in_idle", 32'(o_state), 32'd0);
    pulse_start();
    for (int i = 0; i < 3; i++) write_sample(neg_vec[i]);
    pulse_start();
    check("start_mid_capture", 32'(o_state), 32'd1);
    for (int i = 3; i < 7; i++) write_sample(neg_vec[i]);
    check("not_full_at_7", 32'(o_full), 32'd0);
    write_sample(neg_vec[7]);
    check("full_at_8", 32'(o_full), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(neg_vec[i]);
    pulse_read();
    drain("readout2_complete", 20);

    // Simultaneous start and read in DONE: start wins, no readout.
    pulse_start();
    for (int i = 0; i < 8; i++) write_sample(13'h0A00 + NbData'(i));
    i_start = 1'b1;
    i_read  = 1'b1;
    tick();
    i_start = 1'b0;
    i_read  = 1'b0;
    check("start_read_state", 32'(o_state), 32'd1);
    check("start_read_full", 32'(o_full), 32'd0);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) write_sample(13'h0101 + NbData'(i));
    check("recapture_done", 32'(o_state), 32'd2);

    // Enable freeze after the third readout sample.
    for (int i = 0; i < 8; i++) exp_q.push_back(13'h0101 + NbData'(i));
    pulse_read();
    repeat (4) tick();
    @(negedge clock);
    #1;
    i_enable = 1'b0;
    check("freeze_three_seen", 32'(exp_q.size()), 32'd5);
    repeat (5) begin
      tick();
      check("freeze_valid_low", 32'(o_data_valid), 32'd0);
    end
    check("freeze_state", 32'(o_state), 32'd3);
    i_enable = 1'b1;
    drain("readout3_complete", 20);
    check("readout3_idle", 32'(o_state), 32'd0);

    // Asynchronous reset during READ.
    pulse_start();
    for (int i = 0; i < 8; i++) write_sample(13'h0201 + NbData'(i));
    exp_q.push_back(13'h0201);
    exp_q.push_back(13'h0202);
    pulse_read();
    repeat (3) tick();
    @(negedge clock);
    #1;
    i_reset = 1'b0;
    #1;
    check("areset_state", 32'(o_state), 32'd0);
    check("areset_data", 32'(o_data), 32'd0);
    check("areset_valid", 32'(o_data_valid), 32'd0);
    check("areset_busy", 32'(o_busy), 32'd0);
    check("areset_full", 32'(o_full), 32'd0);
    check("areset_seen_two", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    i_reset = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 8; i++) write_sample(13'h0301 + NbData'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(13'h0301 + NbData'(i));
    pulse_read();
    drain("readout4_complete", 20);
    check("readout4_idle", 32'(o_state), 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_capture_ram.md
# fir_capture_ram

Capture buffer directly downstream of the PRBS→FIR transmit chain. It records the 13-bit FIR output on each sample strobe into an on-chip RAM until the RAM is full, then streams the stored samples back out in order for inspection. A four-state FSM controls it. It shares the transmit chain's clock and consumes the same `valid` strobe the FIR uses.

## Interface
- `NB_DATA`, 13, sample width; matches the FIR output width.
- `NB_ADDR`, 10, RAM address width; `DEPTH = 2**NB_ADDR` samples.

- `clock`  in  1  system clock; rising-edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  global enable; low freezes FSM, pointers and readout.
- `i_valid`  in  1  sample strobe; one-cycle pulse, same strobe that drives the FIR.
- `i_data`  in  NB_DATA  FIR output sample, two's complement.
- `i_start`  in  1  one-cycle pulse; arms a new capture.
- `i_read`  in  1  one-cycle pulse; starts readout of a full buffer.
- `o_data`  out  NB_DATA  read sample.
- `o_data_valid`  out  1  `o_data` holds a stored sample this cycle.
- `o_full`  out  1  buffer holds DEPTH captured samples awaiting readout.
- `o_busy`  out  1  high in CAPTURE or READ.
- `o_state`  out  2  current FSM state, for LEDs/debug.

## Operation
- States, with their `o_state` encodings:
  - IDLE = 0
  - CAPTURE = 1
  - DONE = 2
  - READ = 3
- IDLE:
  - `i_start` → CAPTURE, `wr_ptr` ← 0.
  - `i_read` is ignored.
- CAPTURE:
  - Each cycle with `i_valid` high writes `i_data` to RAM[`wr_ptr`] and increments `wr_ptr`.
  - The write at address DEPTH-1 moves the FSM to DONE on the same edge; `wr_ptr` wraps to 0.
  - `i_start` and `i_read` are ignored.
- DONE:
  - `o_full` = 1.
  - `i_read` → READ, `rd_ptr` ← 0.
  - `i_start` → CAPTURE and discards the old contents (no readout).
  - `i_start` has priority when both are high.
- READ:
  - Addresses 0..DEPTH-1 are presented one per cycle.
  - The cycle after address DEPTH-1 is issued, the FSM goes to IDLE.
  - `i_start` and `i_read` are ignored.
- `i_enable` low:
  - No state change, no RAM write, pointers hold.
  - `o_data_valid` is forced 0.
  - A READ in progress resumes at the same address when enable returns.
  - `i_valid` pulses arriving while disabled are lost.
- Width and pointer rules:
  - `i_data` is stored verbatim; no arithmetic on data.
  - Pointers are NB_ADDR bits and wrap modulo DEPTH.
- Reset (asynchronous, any state):
  - State → IDLE, `wr_ptr` = `rd_ptr` = 0.
  - `o_data` = 0, `o_data_valid` = 0, `o_full` = 0, `o_busy` = 0, `o_state` = 0.
  - RAM contents are not cleared and are undefined after power-up.

## Timing
- RAM write is synchronous: on the `clock` edge where CAPTURE, `i_enable` and `i_valid` are all high.
- Read latency is 1 cycle:
  - Address k is issued on edge N.
  - `o_data` = RAM[k] and `o_data_valid` = 1 after edge N+1.
- Readout duration and ordering:
  - Readout occupies DEPTH consecutive enabled cycles.
  - `o_data_valid` pulses are contiguous when `i_enable` stays high.
  - The last valid sample appears in the first cycle of IDLE.
- `o_data` holds its last value when `o_data_valid` is 0.
- Registered outputs:
  - `o_full`, `o_busy` and `o_state` are registered and change on the edge that changes state.
  - `o_full` drops on the edge leaving DONE.
- At the FIR cadence of one `valid` per 8 clocks, a full capture takes 8·DEPTH cycles.

## Structure
- Shared package `capture_pkg` holds:
  - state encodings (IDLE/CAPTURE/DONE/READ, 2 bits);
  - default `NB_DATA`/`NB_ADDR`;
  - the `DEPTH` function.
- One sub-module, `ram_sdp`: simple dual-port RAM, one write port and one synchronous read port, parameterised by `NB_DATA`/`NB_ADDR`, so it infers block RAM.
- The FSM, pointers and output registers stay in `fir_capture_ram`.

## Test plan
Bench uses `NB_ADDR` = 3 (DEPTH 8) and a `valid` pulse every 8 clocks.
- Full capture and readout:
  - Stimulus: `i_start`, then `i_data` = 0x0001..0x0008 on successive `valid` pulses, then `i_read`.
  - Response: `o_full` rises on the edge of the 8th write. READ yields 8 contiguous `o_data_valid` cycles with 0x0001..0x0008, beginning 2 edges after `i_read`. FSM then returns to `o_state` = 0.
- Negative values:
  - Stimulus: capture 0x1FFF, 0x1000, 0x0FFF.
  - Response: values are read back bit-exact.
- Ignored controls:
  - Stimulus: `i_read` in IDLE; `i_start` mid-CAPTURE after 3 writes.
  - Response: no state change; capture still completes after 8 total writes.
- Simultaneous `i_start` and `i_read` in DONE:
  - Response: FSM → CAPTURE; `o_data_valid` never asserts; `wr_ptr` restarts at 0.
- Enable freeze:
  - Stimulus: drop `i_enable` for 5 cycles after the 3rd readout sample.
  - Response: `o_data_valid` = 0 during the gap; readout resumes with the 4th sample; all 8 samples are delivered in order.
- Asynchronous reset:
  - Stimulus: assert `i_reset` low between edges during READ.
  - Response: all outputs go to 0 immediately, `o_state` = 0. After release, a new capture/readout works from address 0.
